lcd_bus_writer: RTL and testbench

- Downstream stage of the LCD init/message sequencer: accepts {RS, byte} write requests and drives the HD44780-compatible character LCD pins with correct setup, enable-pulse, hold and post-command execution timing.
- Buffers up to FIFO_DEPTH requests, so the sequencer can burst without per-byte handshaking.
- Replaces the fixed-delay pacing previously done upstream: clear/home commands automatically get the long execution wait.

---
 rtl/lcd_bus_writer.sv | 195 +++++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// HD44780 write stage: buffers {RS, byte} requests and paces LCD pins.
// Define LCD_4BIT_EN to send each byte as two nibbles on LCD_DATA[7:4].
module lcd_bus_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 16,
    parameter int T_HOLD_CYC  = 4,
    parameter int T_SHORT_CYC = 2000,
    parameter int T_LONG_CYC  = 80000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oIdle,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [16:0] C_SETUP = 17'(T_SETUP_CYC);
    localparam logic [16:0] C_EN    = 17'(T_EN_CYC);
    localparam logic [16:0] C_HOLD  = 17'(T_HOLD_CYC);
    localparam logic [16:0] C_SHORT = 17'(T_SHORT_CYC);
    localparam logic [16:0] C_LONG  = 17'(T_LONG_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
    } state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [16:0]   cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic [8:0]    head;
    logic          empty, full, push, pop, long_cmd;
`ifdef LCD_4BIT_EN
    logic [8:0]    cur_q, cur_d;
    logic          lo_nib_q, lo_nib_d;
`endif

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH);
    assign push   = iValid && !full;
    assign pop    = (state_q == S_IDLE) && !empty;
    assign head   = mem_q[rd_ptr_q];

    // Clear/home (cmd 0x01..0x03) need the long execution wait
`ifdef LCD_4BIT_EN
    assign long_cmd = !cur_q[8] && (cur_q[7:0] != 8'h00)
                      && (cur_q[7:2] == 6'h00);
`else
    assign long_cmd = !rs_q && (data_q != 8'h00)
                      && (data_q[7:2] == 6'h00);
`endif

    assign oReady   = !full;
    assign oIdle    = (state_q == S_IDLE) && empty;
    assign oDone    = done_q;
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_EN   = en_q;
    assign LCD_RW   = 1'b0;

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge iCLK) begin
        if (push) mem_q[wr_ptr_q] <= {iRS, iDATA};
    end

    // Next-state for FIFO pointers and the pin-timing FSM
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        rs_d     = rs_q;
        data_d   = data_q;
        done_d   = 1'b0;
`ifdef LCD_4BIT_EN
        cur_d    = cur_q;
        lo_nib_d = lo_nib_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    rs_d    = head[8];
`ifdef LCD_4BIT_EN
                    data_d   = {head[7:4], 4'h0};
                    cur_d    = head;
                    lo_nib_d = 1'b0;
`else
                    data_d  = head[7:0];
`endif
                    cnt_d   = C_SETUP;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 17'd1) begin
                    en_d    = 1'b1;
                    cnt_d   = C_EN;
                    state_d = S_EN_HI;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            S_EN_HI: begin
                if (cnt_q == 17'd1) begin
                    en_d    = 1'b0;
                    cnt_d   = C_HOLD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 17'd1) begin
`ifdef LCD_4BIT_EN
                    if (!lo_nib_q) begin
                        lo_nib_d = 1'b1;
                        data_d   = {cur_q[3:0], 4'h0};
                        cnt_d    = C_SETUP;
                        state_d  = S_SETUP;
                    end else begin
                        cnt_d   = long_cmd ? C_LONG : C_SHORT;
                        state_d = S_WAIT;
                    end
`else
                    cnt_d   = long_cmd ? C_LONG : C_SHORT;
                    state_d = S_WAIT;
`endif
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 17'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops EN at once and flushes the FIFO
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
`ifdef LCD_4BIT_EN
            cur_q    <= 9'h000;
            lo_nib_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            done_q   <= done_d;
`ifdef LCD_4BIT_EN
            cur_q    <= cur_d;
            lo_nib_q <= lo_nib_d;
`endif
        end
    end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: pin timing, wait lengths, burst, reset.
// T_LONG_CYC is shortened to keep run time small; other timings are default.
module tb_lcd_bus_writer;
    localparam int LONG  = 10000;
    localparam int SHORT = 2000;
    localparam int GAP_S = 1 + 4 + 16 + 4 + SHORT;
    localparam int GAP_L = 1 + 4 + 16 + 4 + LONG;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] iDATA = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady, oDone, oIdle;
    logic [7:0] LCD_DATA;
    logic       LCD_RW, LCD_EN, LCD_RS;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         rise_t[$];
    logic       rise_rs[$];
    logic [7:0] rise_d[$];
    int         fall_t[$];
    int         done_t[$];
    int         done_n = 0;
    logic       en_prev = 1'b0;

    lcd_bus_writer #(.T_LONG_CYC(LONG), .T_SHORT_CYC(SHORT)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iRS(iRS),
        .iValid(iValid), .oReady(oReady), .oDone(oDone), .oIdle(oIdle),
        .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_RS(LCD_RS)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record EN edges with the bus value at the rising edge, and oDone pulses
    always @(negedge clk) begin
        if (LCD_EN && !en_prev) begin
            rise_t.push_back(cyc);
            rise_rs.push_back(LCD_RS);
            rise_d.push_back(LCD_DATA);
        end
        if (!LCD_EN && en_prev) fall_t.push_back(cyc);
        if (oDone) begin
            done_n = done_n + 1;
            done_t.push_back(cyc);
        end
        en_prev = LCD_EN;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        rise_t.delete();
        rise_rs.delete();
        rise_d.delete();
        fall_t.delete();
        done_t.delete();
        done_n = 0;
    endtask

    // Present one request and hold it until accepted; t = accept edge
    task automatic push(input logic rs, input logic [7:0] d, output int t);
        int n;
        n = 0;
        @(negedge clk);
        iValid = 1'b1;
        iRS = rs;
        iDATA = d;
        while (!oReady && n < 20000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    task automatic wait_done(input int n, input int bound);
        int k;
        k = 0;
        while (done_n < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", done_n, n);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } vec_t;

    vec_t vecs[7];
    int   acc[6];
    int   e0;
    int   t;

    initial begin
        vecs[0] = '{1'b0, 8'h01, GAP_L};
        vecs[1] = '{1'b0, 8'h02, GAP_L};
        vecs[2] = '{1'b0, 8'h03, GAP_L};
        vecs[3] = '{1'b0, 8'h00, GAP_S};
        vecs[4] = '{1'b0, 8'h06, GAP_S};
        vecs[5] = '{1'b1, 8'h01, GAP_S};
        vecs[6] = '{1'b0, 8'h04, GAP_S};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_en", LCD_EN, 0);
        chk("rst_data", LCD_DATA, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_done", oDone, 0);
        chk("rst_ready", oReady, 1);
        chk("rst_idle", oIdle, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();

`ifdef LCD_4BIT_EN
        // Two nibbles on [7:4], RS held, one oDone
        push(1'b1, 8'hA5, e0);
        iValid = 1'b0;
        wait_done(1, 3000);
        chk("n4_rises", rise_t.size(), 2);
        if (rise_t.size() == 2) begin
            chk("n4_hi", rise_d[0], 8'hA0);
            chk("n4_lo", rise_d[1], 8'h50);
            chk("n4_rs0", rise_rs[0], 1);
            chk("n4_rs1", rise_rs[1], 1);
            chk("n4_gap", rise_t[1] - rise_t[0], 16 + 4 + 4);
        end
        chk("n4_idle", oIdle, 1);
`else
        // Single data write timing
        @(negedge clk);
        iValid = 1'b1;
        iRS = 1'b1;
        iDATA = 8'h41;
        @(posedge clk);
        #1;
        e0 = cyc;
        iValid = 1'b0;
        @(negedge clk);
        chk("s_busy", oIdle, 0);
        chk("s_en0", LCD_EN, 0);
        @(negedge clk);
        chk("s_rs", LCD_RS, 1);
        chk("s_data", LCD_DATA, 8'h41);
        chk("s_en1", LCD_EN, 0);
        wait_done(1, 2100);
        chk("s_rises", rise_t.size(), 1);
        if (rise_t.size() == 1) begin
            chk("s_rise_t", rise_t[0] - e0, 5);
            chk("s_fall_t", fall_t[0] - e0, 21);
            chk("s_done_t", done_t[0] - e0, 2025);
        end
        chk("s_idle", oIdle, 1);
        chk("s_keep", LCD_DATA, 8'h41);
        clear_mon();

        // Wait-length table: each byte followed by the next gives a gap
        for (int i = 0; i < 7; i++) push(vecs[i].rs, vecs[i].data, t);
        push(1'b1, 8'h42, t);
        iValid = 1'b0;
        wait_done(8, 50000);
        chk("v_rises", rise_t.size(), 8);
        if (rise_t.size() == 8) begin
            for (int i = 0; i < 7; i++) begin
                chk($sformatf("v%0d_rs", i), rise_rs[i], vecs[i].rs);
                chk($sformatf("v%0d_data", i), rise_d[i], vecs[i].data);
                chk($sformatf("v%0d_gap", i),
                    rise_t[i+1] - rise_t[i], vecs[i].gap);
            end
        end
        clear_mon();

        // Burst: five taken on consecutive edges, sixth after a pop
        for (int i = 0; i < 5; i++) push(1'b1, 8'h30 + 8'(i), acc[i]);
        @(negedge clk);
        chk("b_full", oReady, 0);
        push(1'b1, 8'h35, acc[5]);
        iValid = 1'b0;
        for (int i = 1; i < 5; i++)
            chk($sformatf("b_acc%0d", i), acc[i] - acc[0], i);
        wait_done(6, 14000);
        chk("b_rises", rise_t.size(), 6);
        if (rise_t.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("b%0d_data", i), rise_d[i], 8'h30 + i);
            for (int i = 0; i < 5; i++)
                chk($sformatf("b%0d_gap", i), rise_t[i+1] - rise_t[i], GAP_S);
        end
        clear_mon();
`endif

        // Reset while EN is high with three requests queued
        for (int i = 0; i < 4; i++) push(1'b1, 8'h50 + 8'(i), t);
        iValid = 1'b0;
        t = 0;
        while (!LCD_EN && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("r_en_seen", LCD_EN, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_en_drop", LCD_EN, 0);
        chk("r_ready", oReady, 1);
        chk("r_idle", oIdle, 1);
        chk("r_data", LCD_DATA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (3000) @(negedge clk);
        chk("r_no_en", rise_t.size(), 0);
        chk("r_no_done", done_n, 0);
        chk("r_idle2", oIdle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
